mem_access: RTL
===============

# mem_access

Memory-access stage of the pipelined RISC-V core. It consumes the packed execute-to-memory pipeline register and performs loads and stores over a request/acknowledge data-memory port. It aligns store data and extracts load data, freezes upstream stages while an access is outstanding, and registers the memory-to-writeback pipeline register. It also exports the EX/MEM forwarding value and a stall-cycle counter.

## Interface
- REG_WIDTH, 32, data width
- REG_COUNT, 32, register-file entries
- CTRL_SIZE, 21, full decode control width
- REG_BITS, $clog2(REG_COUNT), register index width
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- exc_mem_reg  in  REG_BITS+1+CTRL_SIZE-7+3*REG_WIDTH  packed {rd, write_en, ctrl[13:0], alu_out, store_data, return_pc}
  - ctrl[13] mem_read; ctrl[12] mem_write; ctrl[11:9] funct3
  - ctrl[8:7] wb_sel: 00 alu_out, 01 load data, 10 return_pc, 11 = alu_out
  - ctrl[6:0] ignored
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address {alu_out[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  load word
- mem_stall  out  1  combinational; holds exc_mem_reg and all earlier stages
- fwd_data  out  REG_WIDTH  combinational EX/MEM forwarding value: alu_out, or return_pc when wb_sel=10
- mem_wb_reg  out  REG_BITS+1+REG_WIDTH  {rd, write_en, wb_data}
- misalign_err  out  1  one-cycle pulse for an illegal or misaligned access
- stall_cycles  out  32  saturating count of cycles with mem_stall=1

## Operation
- Classification:
  - is_mem = mem_read | mem_write.
  - When both are set, the access is a store.
  - off = alu_out[1:0].
- Legal accesses:
  - Stores: SB (000), SH (001), SW (010).
  - Loads: LB (000), LH (001), LW (010), LBU (100), LHU (101).
  - Illegal: any other funct3 for the access kind; H with off[0]=1; W with off≠0.
- Illegal access handling: no request is issued and mem_stall=0. The instruction completes in one cycle with write_en forced to 0, and misalign_err pulses.
- Byte enables: B = 4'b0001<<off; H = 4'b0011<<off; W = 4'b1111.
- Store data: wdata = {4{sd[7:0]}}, {2{sd[15:0]}}, or sd.
- Load data: rdata>>(8*off), then sign-extend for LB/LH or zero-extend for LBU/LHU; LW is unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, legal is_mem: mem_stall=1. At the next edge, load dmem_* and set dmem_req=1, then go to BUSY.
  - BUSY: mem_stall=1 and dmem_* are held stable. On an edge with dmem_ack=1, capture the aligned load data in lbuf, clear dmem_req, and go to DONE.
  - DONE: mem_stall=0. At the next edge, mem_wb_reg takes the instruction using lbuf, and the FSM returns to IDLE.
  - IDLE, non-mem or illegal: the instruction passes straight through in one cycle.
- While mem_stall=1, mem_wb_reg is loaded with a bubble: rd=0, write_en=0, wb_data=0.
- dmem_ack is ignored in IDLE and DONE.
- stall_cycles increments on every edge with mem_stall=1 and saturates at 32'hFFFFFFFF.

## Timing
- Reset values: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_wb_reg, misalign_err and stall_cycles are all 0; FSM is in IDLE.
- Non-memory instruction: mem_wb_reg is valid one edge after it appears, with no stall.
- Memory access with ack k cycles after dmem_req rises (k≥0): mem_stall is high for k+2 cycles, and mem_wb_reg is valid k+3 edges after the instruction appears.
- Back-to-back accesses: the next exc_mem_reg value arrives on the DONE→IDLE edge and is classified in IDLE the following cycle.
- Reset asserted mid-access: everything returns to reset values immediately. A late dmem_ack after reset release is ignored because the FSM is in IDLE.

## Test plan
- ADD, wb_sel=00, alu_out=0x1234, rd=5, write_en=1 -> next edge mem_wb_reg={5,1,0x1234}; mem_stall never high.
- LB alu_out=0x103, dmem_rdata=0x80FF_FFFF, ack one cycle after req -> dmem_addr=0x100, be=0001<<3=1000, wb_data=0xFFFFFF80; mem_stall high for 3 cycles; stall_cycles=3.
- SH alu_out=0x202, store_data=0xABCD1234, ack in first BUSY cycle -> dmem_we=1, be=1100, wdata=0x12341234; mem_wb_reg write_en=0 if decoded so.
- LW alu_out=0x101 -> no dmem_req; misalign_err pulses once; mem_wb_reg write_en=0; no stall.
- JAL in EX/MEM with return_pc=0x48, wb_sel=10 -> fwd_data=0x48 and wb_data=0x48.
- Load in BUSY, rstn pulsed low, then ack arrives after release -> dmem_req=0, mem_wb_reg=0, FSM stays IDLE, stall_cycles=0.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: aligns stores, extracts loads, registers the MEM/WB pipeline register.
// Latency: one edge for non-memory or illegal instructions; k+3 edges for an access acked k cycles after request.
// Backpressure: mem_stall holds exc_mem_reg and all earlier stages from classification until the ack is taken.
module mem_access #(
    parameter int REG_WIDTH = 32,
    parameter int REG_COUNT = 32,
    parameter int CTRL_SIZE = 21,
    parameter int REG_BITS  = $clog2(REG_COUNT)
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic [REG_BITS+1+CTRL_SIZE-7+3*REG_WIDTH-1:0] exc_mem_reg,
    output logic                                         dmem_req,
    output logic                                         dmem_we,
    output logic [31:0]                                  dmem_addr,
    output logic [3:0]                                   dmem_be,
    output logic [31:0]                                  dmem_wdata,
    input  logic                                         dmem_ack,
    input  logic [31:0]                                  dmem_rdata,
    output logic                                         mem_stall,
    output logic [REG_WIDTH-1:0]                         fwd_data,
    output logic [REG_BITS+1+REG_WIDTH-1:0]              mem_wb_reg,
    output logic                                         misalign_err,
    output logic [31:0]                                  stall_cycles
);

    // Field positions inside the packed EX/MEM register (return_pc sits at the bottom).
    localparam int P_SD   = REG_WIDTH;
    localparam int P_ALU  = 2 * REG_WIDTH;
    localparam int P_CTRL = 3 * REG_WIDTH;
    localparam int P_WE   = P_CTRL + CTRL_SIZE - 7;
    localparam int P_RD   = P_WE + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [REG_WIDTH-1:0]      return_pc, store_data, alu_out;
    logic [CTRL_SIZE-8:0]      ctrl;
    logic                      write_en;
    logic [REG_BITS-1:0]       rd;
    logic                      mem_read, mem_write, is_mem;
    logic [2:0]                funct3;
    logic [1:0]                wb_sel, off;
    logic                      legal;
    logic [1:0]                size;       // 0 byte, 1 half, 2 word
    logic                      load_signed;
    logic [3:0]                be;
    logic [31:0]               wdata, shifted, load_val;
    logic [31:0]               lbuf;
    logic [REG_WIDTH-1:0]      wb_data;
    logic                      start, illegal;
    logic                      unused_ctrl;

    assign return_pc  = exc_mem_reg[0 +: REG_WIDTH];
    assign store_data = exc_mem_reg[P_SD +: REG_WIDTH];
    assign alu_out    = exc_mem_reg[P_ALU +: REG_WIDTH];
    assign ctrl       = exc_mem_reg[P_CTRL +: CTRL_SIZE-7];
    assign write_en   = exc_mem_reg[P_WE];
    assign rd         = exc_mem_reg[P_RD +: REG_BITS];

    assign mem_read  = ctrl[13];
    assign mem_write = ctrl[12];
    assign funct3    = ctrl[11:9];
    assign wb_sel    = ctrl[8:7];
    assign is_mem    = mem_read | mem_write;
    assign off       = alu_out[1:0];
    assign unused_ctrl = ^ctrl[6:0];

    // Decode access size/sign and legality; a set mem_write always wins over mem_read.
    always_comb begin
        legal       = 1'b0;
        size        = 2'd0;
        load_signed = 1'b0;
        if (mem_write) begin
            case (funct3)
                3'b000: begin legal = 1'b1;          size = 2'd0; end
                3'b001: begin legal = ~off[0];       size = 2'd1; end
                3'b010: begin legal = (off == 2'd0); size = 2'd2; end
                default: legal = 1'b0;
            endcase
        end else if (mem_read) begin
            case (funct3)
                3'b000: begin legal = 1'b1;          size = 2'd0; load_signed = 1'b1; end
                3'b001: begin legal = ~off[0];       size = 2'd1; load_signed = 1'b1; end
                3'b010: begin legal = (off == 2'd0); size = 2'd2; end
                3'b100: begin legal = 1'b1;          size = 2'd0; end
                3'b101: begin legal = ~off[0];       size = 2'd1; end
                default: legal = 1'b0;
            endcase
        end
    end

    assign start   = is_mem & legal;
    assign illegal = is_mem & ~legal;

    // Byte enables and lane-replicated store data for the decoded size.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data[31:0];
        case (size)
            2'd0: begin be = 4'b0001 << off; wdata = {4{store_data[7:0]}};  end
            2'd1: begin be = 4'b0011 << off; wdata = {2{store_data[15:0]}}; end
            default: begin be = 4'b1111;     wdata = store_data[31:0];      end
        endcase
    end

    // Shift the addressed lane down and extend it to a full word.
    always_comb begin
        shifted  = dmem_rdata >> {off, 3'b000};
        load_val = shifted;
        case (size)
            2'd0: load_val = {{24{load_signed & shifted[7]}},  shifted[7:0]};
            2'd1: load_val = {{16{load_signed & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Next state and stall; only IDLE looks at the incoming instruction, only BUSY looks at ack.
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mem_stall = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dmem_ack) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write-back value; load data only exists once an access has completed.
    always_comb begin
        case (wb_sel)
            2'b01:   wb_data = (state_q == DONE) ? lbuf : '0;
            2'b10:   wb_data = return_pc;
            default: wb_data = alu_out;
        endcase
    end

    assign fwd_data = (wb_sel == 2'b10) ? return_pc : alu_out;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Data-memory port: loaded when an access starts, held through BUSY, request dropped on ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            lbuf       <= '0;
        end else if (state_q == IDLE && start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_out[31:2], 2'b00};
            dmem_be    <= be;
            dmem_wdata <= wdata;
        end else if (state_q == BUSY && dmem_ack) begin
            dmem_req <= 1'b0;
            lbuf     <= load_val;
        end
    end

    // MEM/WB register: bubble while stalled, illegal accesses retire without writing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_wb_reg <= '0;
        end else if (mem_stall) begin
            mem_wb_reg <= '0;
        end else begin
            mem_wb_reg <= {rd, write_en & ~(illegal & (state_q == IDLE)), wb_data};
        end
    end

    // One-cycle error pulse for an illegal access retiring from IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) misalign_err <= 1'b0;
        else       misalign_err <= (state_q == IDLE) & illegal;
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                 stall_cycles <= '0;
        else if (mem_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end

endmodule
